// File: rtl/led16_scroll_ctrl.sv
// Scroll sequencer for four active-low 16-segment digits: message buffer, tick divider, RUN/FLUSH FSM.
// Optional end-of-message hold in loop mode is enabled by defining LED_SCROLL_PAUSE_EN.
module led16_scroll_ctrl #(
    parameter int          MSG_DEPTH   = 32,
    parameter int          ADDR_W      = 5,
    parameter int          TICK_DIV    = 2097152,
    parameter int          PAUSE_TICKS = 4,
    parameter logic [15:0] BLANK       = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [15:0]       LEDa,
    output logic [15:0]       LEDb,
    output logic [15:0]       LEDc,
    output logic [15:0]       LEDd
);

    localparam int              TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(MSG_DEPTH);

    if (TICK_DIV < 2 || PAUSE_TICKS < 1) begin : g_bad_param
        $error("led16_scroll_ctrl: TICK_DIV must be >= 2 and PAUSE_TICKS >= 1");
    end

`ifdef LED_SCROLL_PAUSE_EN
    localparam int            PW         = $clog2(PAUSE_TICKS + 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
`endif

    state_t            r_state, w_state_nx;
    logic [15:0]       r_buf [MSG_DEPTH];
    logic [15:0]       r_led_a, r_led_b, r_led_c, r_led_d;
    logic [TW-1:0]     r_tick_cnt;
    logic [ADDR_W-1:0] r_rd_ptr, w_ptr_nx;
    logic [ADDR_W:0]   r_len;
    logic              r_loop;
    logic [1:0]        r_flush_cnt, w_flush_nx;
    logic              r_busy, r_done, r_wrap;
`ifdef LED_SCROLL_PAUSE_EN
    logic [PW-1:0]     r_pause_cnt, w_pause_nx;
`endif

    logic            w_tick, w_len_ok, w_accept, w_shift, w_blank_in, w_clear, w_done, w_wrap;
    logic [ADDR_W:0] w_len_m1;

    assign w_tick   = (r_tick_cnt == TICK_LAST);
    assign w_len_ok = (msg_len != '0) && (msg_len <= DEPTH_L);
    assign w_len_m1 = r_len - 1'b1;

    // Buffer has no reset; the shift reads the pre-edge contents, so a same-edge write is seen next time.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_buf[wr_addr] <= wr_data;
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_rd_ptr;
        w_flush_nx = r_flush_cnt;
        w_accept   = 1'b0;
        w_shift    = 1'b0;
        w_blank_in = 1'b0;
        w_clear    = 1'b0;
        w_done     = 1'b0;
        w_wrap     = 1'b0;
`ifdef LED_SCROLL_PAUSE_EN
        w_pause_nx = r_pause_cnt;
`endif
        if (r_state != S_IDLE && stop) begin
            w_state_nx = S_IDLE;
            w_ptr_nx   = '0;
            w_clear    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_len_ok) begin
                        w_accept   = 1'b1;
                        w_state_nx = S_RUN;
                        w_ptr_nx   = '0;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_shift = 1'b1;
                        if ({1'b0, r_rd_ptr} != w_len_m1) begin
                            w_ptr_nx = r_rd_ptr + 1'b1;
                        end else begin
                            w_ptr_nx = '0;
                            if (!r_loop) begin
                                w_state_nx = S_FLUSH;
                                w_flush_nx = '0;
                            end else begin
`ifdef LED_SCROLL_PAUSE_EN
                                w_state_nx = S_PAUSE;
                                w_pause_nx = '0;
`else
                                w_wrap = 1'b1;
`endif
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // Four blank shifts push the whole message off the left edge.
                    if (w_tick) begin
                        w_shift    = 1'b1;
                        w_blank_in = 1'b1;
                        if (r_flush_cnt == 2'd3) begin
                            w_state_nx = S_IDLE;
                            w_done     = 1'b1;
                        end else begin
                            w_flush_nx = r_flush_cnt + 1'b1;
                        end
                    end
                end
`ifdef LED_SCROLL_PAUSE_EN
                S_PAUSE: begin
                    if (w_tick) begin
                        if (r_pause_cnt == PAUSE_LAST) begin
                            w_state_nx = S_RUN;
                            w_ptr_nx   = '0;
                            w_wrap     = 1'b1;
                        end else begin
                            w_pause_nx = r_pause_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    w_state_nx = S_IDLE;
                    w_clear    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
            r_rd_ptr    <= '0;
            r_flush_cnt <= '0;
            r_tick_cnt  <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_led_a     <= BLANK;
            r_led_b     <= BLANK;
            r_led_c     <= BLANK;
            r_led_d     <= BLANK;
`ifdef LED_SCROLL_PAUSE_EN
            r_pause_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_busy      <= (w_state_nx != S_IDLE);
            r_done      <= w_done;
            r_wrap      <= w_wrap;
            r_rd_ptr    <= w_ptr_nx;
            r_flush_cnt <= w_flush_nx;
`ifdef LED_SCROLL_PAUSE_EN
            r_pause_cnt <= w_pause_nx;
`endif
            if (w_accept) begin
                r_len  <= msg_len;
                r_loop <= loop;
            end
            if (r_state == S_IDLE || w_state_nx == S_IDLE || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;
            if (w_clear) begin
                r_led_a <= BLANK;
                r_led_b <= BLANK;
                r_led_c <= BLANK;
                r_led_d <= BLANK;
            end else if (w_shift) begin
                r_led_a <= r_led_b;
                r_led_b <= r_led_c;
                r_led_c <= r_led_d;
                r_led_d <= w_blank_in ? BLANK : r_buf[r_rd_ptr];
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign wrap = r_wrap;
    assign LEDa = r_led_a;
    assign LEDb = r_led_b;
    assign LEDc = r_led_c;
    assign LEDd = r_led_d;

endmodule

// File: tb/tb_led16_scroll_ctrl.sv
// Self-checking bench for led16_scroll_ctrl against a step-arithmetic reference model.
module tb_led16_scroll_ctrl;

    localparam int TD = 4;
`ifdef LED_SCROLL_PAUSE_EN
    localparam int PSTEPS = 2;
`else
    localparam int PSTEPS = 0;
`endif
    localparam logic [15:0] BL = 16'hFFFF;

    logic        clk, rst_n, wr_en, loop, start, stop;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  msg_len;
    logic        busy, done, wrap;
    logic [15:0] LEDa, LEDb, LEDc, LEDd;

    int errors = 0;
    int checks = 0;

    led16_scroll_ctrl #(
        .MSG_DEPTH(32), .ADDR_W(5), .TICK_DIV(TD), .PAUSE_TICKS(2), .BLANK(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .loop(loop), .start(start), .stop(stop),
        .busy(busy), .done(done), .wrap(wrap),
        .LEDa(LEDa), .LEDb(LEDb), .LEDc(LEDc), .LEDd(LEDd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the display after step n is the last four items of the shifted stream.
    logic [15:0] m_led [4];
    logic [15:0] m_buf [32];
    int          m_cyc, m_len, mn, mper, mp;
    bit          m_loop, m_busy, m_done, m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_led[i] = BL;
            m_busy = 0; m_done = 0; m_wrap = 0; m_cyc = 0; m_len = 0; m_loop = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if (m_busy) begin
                if (stop) begin
                    m_busy = 0;
                    for (int i = 0; i < 4; i++) m_led[i] = BL;
                end else begin
                    m_cyc++;
                    if (m_cyc % TD == 0) begin
                        mn = m_cyc / TD;
                        if (!m_loop) begin
                            m_led[0] = m_led[1]; m_led[1] = m_led[2]; m_led[2] = m_led[3];
                            m_led[3] = (mn <= m_len) ? m_buf[mn-1] : BL;
                            if (mn == m_len + 4) begin m_busy = 0; m_done = 1; end
                        end else begin
                            mper = m_len + PSTEPS;
                            mp   = (mn - 1) % mper;
                            if (mp < m_len) begin
                                m_led[0] = m_led[1]; m_led[1] = m_led[2]; m_led[2] = m_led[3];
                                m_led[3] = m_buf[mp];
                            end
                            if (mn % mper == 0) m_wrap = 1;
                        end
                    end
                end
            end else if (start && !stop && msg_len >= 1 && msg_len <= 32) begin
                m_busy = 1; m_len = int'(msg_len); m_loop = loop; m_cyc = 0;
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
        end
    end

    wire [66:0] obs   = {LEDa, LEDb, LEDc, LEDd, busy, done, wrap};
    wire [66:0] m_exp = {m_led[0], m_led[1], m_led[2], m_led[3], m_busy, m_done, m_wrap};

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic kick(input int len, input bit lp);
        msg_len = 6'(len); loop = lp; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; msg_len = 0; loop = 0; start = 0; stop = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== {{4{BL}}, 3'b000}) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, {{4{BL}}, 3'b000}); end
        rst_n = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs, m_exp); end
        end
        checks++;
        if (obs !== {{4{BL}}, 3'b000}) begin errors++; $display("FAIL reset_idle_end got=%h exp=%h", obs, {{4{BL}}, 3'b000}); end
    endtask

    task automatic test_oneshot;
        int ndone = 0;
        wr(0, 16'hFFFE); wr(1, 16'hFFFD); wr(2, 16'hFFFB);
        kick(3, 0);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (done) ndone++;
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL oneshot c=%0d got=%h exp=%h", c, obs, m_exp); end
            if (c == 4) begin
                checks++;
                if (LEDd !== 16'hFFFE) begin errors++; $display("FAIL oneshot_step1 got=%h exp=fffe", LEDd); end
            end
            if (c == 8) begin
                checks++;
                if (LEDd !== 16'hFFFD) begin errors++; $display("FAIL oneshot_step2 got=%h exp=fffd", LEDd); end
            end
            if (c == 28) begin
                checks++;
                if (obs !== {{4{BL}}, 3'b010}) begin errors++; $display("FAIL oneshot_done got=%h exp=%h", obs, {{4{BL}}, 3'b010}); end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL oneshot_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_loop;
        kick(3, 1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL loop c=%0d got=%h exp=%h", c, obs, m_exp); end
`ifdef LED_SCROLL_PAUSE_EN
            if (c > 12 && c < 24) begin
                checks++;
                if ({LEDa, LEDb, LEDc, LEDd} !== {BL, 16'hFFFE, 16'hFFFD, 16'hFFFB}) begin
                    errors++; $display("FAIL pause_hold c=%0d got=%h", c, {LEDa, LEDb, LEDc, LEDd});
                end
            end
            if (c == 20) begin
                checks++;
                if (wrap !== 1'b1) begin errors++; $display("FAIL pause_wrap got=%b exp=1", wrap); end
            end
            if (c == 24) begin
                checks++;
                if (LEDd !== 16'hFFFE) begin errors++; $display("FAIL pause_entry0 got=%h exp=fffe", LEDd); end
            end
`else
            if (c == 12) begin
                checks++;
                if (wrap !== 1'b1) begin errors++; $display("FAIL loop_wrap got=%b exp=1", wrap); end
            end
            if (c == 16) begin
                checks++;
                if (LEDd !== 16'hFFFE) begin errors++; $display("FAIL loop_step4 got=%h exp=fffe", LEDd); end
            end
            if (c == 24) begin
                checks++;
                if ({LEDa, LEDb, LEDc, LEDd} !== {16'hFFFB, 16'hFFFE, 16'hFFFD, 16'hFFFB}) begin
                    errors++; $display("FAIL loop_step6 got=%h", {LEDa, LEDb, LEDc, LEDd});
                end
            end
`endif
        end
        stop = 1;
        @(negedge clk);
        stop = 0;
        checks++;
        if (obs !== {{4{BL}}, 3'b000}) begin errors++; $display("FAIL loop_stop got=%h exp=%h", obs, {{4{BL}}, 3'b000}); end
    endtask

    task automatic test_stop;
        kick(3, 0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 8) stop = 1;
            @(negedge clk);
            stop = 0;
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL stop c=%0d got=%h exp=%h", c, obs, m_exp); end
            if (c == 8) begin
                checks++;
                if (obs !== {{4{BL}}, 3'b000}) begin errors++; $display("FAIL stop_blank got=%h exp=%h", obs, {{4{BL}}, 3'b000}); end
            end
        end
        kick(3, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL restart c=%0d got=%h exp=%h", c, obs, m_exp); end
        end
        checks++;
        if (LEDd !== 16'hFFFE) begin errors++; $display("FAIL restart_entry0 got=%h exp=fffe", LEDd); end
        stop = 1;
        @(negedge clk);
        stop = 0;
    endtask

    task automatic test_bad_start;
        for (int k = 0; k < 2; k++) begin
            msg_len = (k == 0) ? 6'd0 : 6'd33; start = 1;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || obs !== m_exp) begin errors++; $display("FAIL bad_len len=%0d got=%h exp=%h", msg_len, obs, m_exp); end
            end
            start = 0;
        end
        kick(3, 0);
        for (int c = 1; c <= 14; c++) begin
            if (c >= 2 && c <= 5) begin start = 1; msg_len = 6'd1; loop = 1; end
            else start = 0;
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL start_busy c=%0d got=%h exp=%h", c, obs, m_exp); end
            if (c == 12) begin
                checks++;
                if (LEDd !== 16'hFFFB || busy !== 1'b1) begin errors++; $display("FAIL start_busy_step3 got=%h/%b exp=fffb/1", LEDd, busy); end
            end
        end
        start = 0;
        stop = 1;
        @(negedge clk);
        stop = 0;
    endtask

    task automatic test_collision;
        kick(3, 1);
        for (int c = 1; c <= 4 * (5 + PSTEPS); c++) begin
            if (c == 8) begin wr_en = 1; wr_addr = 5'd1; wr_data = 16'h1234; end
            @(negedge clk);
            wr_en = 0;
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL collision c=%0d got=%h exp=%h", c, obs, m_exp); end
            if (c == 8) begin
                checks++;
                if (LEDd !== 16'hFFFD) begin errors++; $display("FAIL collision_old got=%h exp=fffd", LEDd); end
            end
        end
        checks++;
        if (LEDd !== 16'h1234) begin errors++; $display("FAIL collision_new got=%h exp=1234", LEDd); end
        stop = 1;
        @(negedge clk);
        stop = 0;
    endtask

    task automatic test_midreset;
        kick(3, 1);
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL midreset_pre got=%h exp=%h", obs, m_exp); end
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs !== {{4{BL}}, 3'b000}) begin errors++; $display("FAIL midreset_blank got=%h exp=%h", obs, {{4{BL}}, 3'b000}); end
        @(negedge clk);
        rst_n = 1;
        kick(2, 0);
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL midreset_post got=%h exp=%h", obs, m_exp); end
        end
    endtask

    task automatic test_random;
        for (int a = 0; a < 32; a++) wr(5'(a), 16'($urandom));
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 5'($urandom);
            wr_data = 16'($urandom);
            start   = ($urandom % 8) == 0;
            stop    = ($urandom % 60) == 0;
            msg_len = 6'($urandom_range(0, 33));
            loop    = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, m_exp); end
        end
        wr_en = 0; start = 0; stop = 0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_stop();
        test_bad_start();
        test_collision();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
